// File: rtl/ni_pkt_enc.sv
// Network-interface packet encoder: builds head/body/tail flits and injects them under credit flow.
// Optional MCAST_SELF_STRIP_EN removes this node's own bit from multicast masks.
module ni_pkt_enc #(
    parameter int unsigned MY_X    = 0,
    parameter int unsigned MY_Y    = 0,
    parameter int unsigned ARRAY_W = 8,
    parameter int unsigned CREDITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_um,
    input  logic [10:0] req_dst,
    input  logic [55:0] req_mask,
    input  logic [3:0]  req_len,
    input  logic [51:0] req_hdata,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic [63:0] pl_data,
    output logic [65:0] flit_out,
    output logic        flit_valid,
    input  logic        credit_in,
    output logic        busy,
    output logic        pkt_sent,
    output logic        drop
);

    localparam int unsigned OwnId = MY_Y * ARRAY_W + MY_X;
    localparam int unsigned CntW  = $clog2(CREDITS + 1);

    if (OwnId > 55) begin : g_bad_id
        $error("ni_pkt_enc: own node id outside 0..55");
    end

    typedef enum logic [1:0] {StIdle, StHead, StBody, StDrop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      rem_q, rem_d;
    logic            um_q;
    logic [10:0]     dst_q;
    logic [55:0]     mask_q;
    logic [3:0]      len_q;
    logic [51:0]     hdata_q;

    logic [55:0]     eff_mask;
    logic [63:0]     head_word;
    logic [65:0]     flit_d;
    logic            launch, sent_d, drop_d;
    logic            accept, pl_hs, cnt_pos;

    always_comb begin
`ifdef MCAST_SELF_STRIP_EN
        eff_mask = req_mask & ~(56'd1 << OwnId);
`else
        eff_mask = req_mask;
`endif
    end

    assign accept    = req_valid && req_ready;
    assign pl_hs     = pl_valid && pl_ready;
    assign cnt_pos   = (cnt_q != '0);
    assign head_word = um_q ? {1'b1, mask_q, 7'd0} : {1'b0, dst_q, hdata_q};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        launch  = 1'b0;
        flit_d  = flit_out;
        sent_d  = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    rem_d = req_len;
                    // Empty multicast: nothing to send, but its payload must still be drained
                    if (req_um && eff_mask == '0) begin
                        if (req_len == 4'd0) drop_d = 1'b1;
                        else                 state_d = StDrop;
                    end else begin
                        state_d = StHead;
                    end
                end
            end
            StHead: begin
                if (cnt_pos) begin
                    launch = 1'b1;
                    rem_d  = len_q;
                    if (len_q == 4'd0) begin
                        flit_d  = {2'b11, head_word};
                        sent_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        flit_d  = {2'b00, head_word};
                        state_d = StBody;
                    end
                end
            end
            StBody: begin
                if (pl_hs && cnt_pos) begin
                    launch = 1'b1;
                    rem_d  = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        flit_d  = {2'b10, pl_data};
                        sent_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        flit_d  = {2'b01, pl_data};
                    end
                end
            end
            StDrop: begin
                if (pl_hs) begin
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        drop_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Launch and credit return on the same edge cancel; returns beyond CREDITS are ignored
    always_comb begin
        cnt_d = cnt_q;
        if (launch && !credit_in) begin
            cnt_d = cnt_q - 1'b1;
        end else if (!launch && credit_in && cnt_q != CntW'(CREDITS)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= CntW'(CREDITS);
            rem_q      <= '0;
            um_q       <= 1'b0;
            dst_q      <= '0;
            mask_q     <= '0;
            len_q      <= '0;
            hdata_q    <= '0;
            flit_out   <= '0;
            flit_valid <= 1'b0;
            pkt_sent   <= 1'b0;
            drop       <= 1'b0;
            req_ready  <= 1'b1;
            pl_ready   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            flit_out   <= flit_d;
            flit_valid <= launch;
            pkt_sent   <= sent_d;
            drop       <= drop_d;
            req_ready  <= (state_d == StIdle);
            pl_ready   <= (state_d == StBody && cnt_d != '0) || (state_d == StDrop);
            busy       <= (state_d != StIdle);
            if (state_q == StIdle && accept) begin
                um_q    <= req_um;
                dst_q   <= req_dst;
                mask_q  <= eff_mask;
                len_q   <= req_len;
                hdata_q <= req_hdata;
            end
        end
    end

endmodule

// File: tb/tb_ni_pkt_enc.sv
// Bench for ni_pkt_enc: packet-level reference model (expected flit list, credit balance)
// plus directed timing, credit-stall, drop and reset cases and randomized packets.
module tb_ni_pkt_enc;

    localparam int unsigned CREDITS = 4;
    localparam int unsigned OWN     = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_um;
    logic [10:0] req_dst;
    logic [55:0] req_mask;
    logic [3:0]  req_len;
    logic [51:0] req_hdata;
    logic        pl_valid, pl_ready;
    logic [63:0] pl_data;
    logic [65:0] flit_out;
    logic        flit_valid, credit_in, busy, pkt_sent, drop;

    always #5 clk = ~clk;

    ni_pkt_enc #(.MY_X(0), .MY_Y(0), .ARRAY_W(8), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_um(req_um), .req_dst(req_dst),
        .req_mask(req_mask), .req_len(req_len), .req_hdata(req_hdata),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .flit_out(flit_out), .flit_valid(flit_valid), .credit_in(credit_in),
        .busy(busy), .pkt_sent(pkt_sent), .drop(drop)
    );

    int          passed = 0;
    int          total  = 0;
    logic [65:0] expq[$];
    logic [63:0] pw[16];
    int          pidx, plen, model_cnt, drop_obs, launches;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // One clock: sample pre-edge handshakes, then check the flits the edge produced
    task automatic tick();
        logic [65:0] e;
        bit ci, phs, rhs;
        ci  = credit_in;
        phs = pl_valid && pl_ready;
        rhs = req_valid && req_ready;
        @(posedge clk);
        #1;
        if (flit_valid) begin
            launches++;
            chk("credit_avail", model_cnt > 0, 1'b1);
            if (expq.size() == 0) begin
                chk("unexpected_flit", flit_valid, 1'b0);
            end else begin
                e = expq.pop_front();
                chk("flit", flit_out, e);
                chk("pkt_sent", pkt_sent, expq.size() == 0);
            end
        end else if (pkt_sent) begin
            chk("pkt_sent_stray", pkt_sent, 1'b0);
        end
        if (flit_valid && !ci)                             model_cnt--;
        else if (!flit_valid && ci && model_cnt < CREDITS) model_cnt++;
        if (drop) drop_obs++;
        if (phs) pidx++;
        pl_data = (pidx < 16) ? pw[pidx] : 64'd0;
        if (rhs) req_valid = 1'b0;
    endtask

    // Packet-level model: expected flit list from the request, and whether it is dropped
    task automatic model_req(input bit um, input logic [10:0] dst, input logic [55:0] mask,
                             input logic [3:0] len, input logic [51:0] hd, output bit dropped);
        logic [55:0] eff;
        logic [63:0] h;
        eff = mask;
`ifdef MCAST_SELF_STRIP_EN
        eff[OWN] = 1'b0;
`endif
        dropped = um && (eff == 56'd0);
        plen = int'(len);
        pidx = 0;
        drop_obs = 0;
        pl_data = pw[0];
        if (!dropped) begin
            h = um ? {1'b1, eff, 7'd0} : {1'b0, dst, hd};
            expq.push_back({(len == 4'd0) ? 2'b11 : 2'b00, h});
            for (int i = 0; i < plen; i++)
                expq.push_back({(i == plen - 1) ? 2'b10 : 2'b01, pw[i]});
        end
        req_um = um; req_dst = dst; req_mask = mask; req_len = len; req_hdata = hd;
        req_valid = 1'b1;
    endtask

    task automatic refill();
        int n;
        n = 0;
        while (model_cnt < CREDITS && n < 10) begin
            credit_in = 1'b1;
            tick();
            n++;
        end
        credit_in = 1'b0;
    endtask

    task automatic run_pkt(input bit um, input logic [10:0] dst, input logic [55:0] mask,
                           input logic [3:0] len, input logic [51:0] hd, input int vp,
                           input int cp);
        bit dropped;
        int cyc;
        model_req(um, dst, mask, len, hd, dropped);
        cyc = 0;
        while (cyc < 400 && (req_valid || pidx < plen || expq.size() != 0 ||
                             (dropped && drop_obs == 0))) begin
            pl_valid  = (pidx < plen) && (int'($urandom_range(99)) < vp);
            credit_in = (int'($urandom_range(99)) < cp);
            tick();
            cyc++;
        end
        pl_valid  = 1'b0;
        credit_in = 1'b0;
        tick();
        chk("pkt_done", cyc < 400, 1'b1);
        chk("drop_count", drop_obs, dropped);
        chk("payload_used", pidx, plen);
        chk("busy_after", busy, 1'b0);
        expq.delete();
    endtask

    initial begin
        bit          dr;
        logic [63:0] r;
        logic [55:0] m;
        int          c;
        rst = 1'b1;
        req_valid = 0; req_um = 0; req_dst = 0; req_mask = 0; req_len = 0; req_hdata = 0;
        pl_valid = 0; pl_data = 0; credit_in = 0;
        model_cnt = CREDITS; launches = 0; pidx = 0; plen = 0; drop_obs = 0;
        #12;
        chk("rst_flit_out", flit_out, 66'd0);
        chk("rst_flit_valid", flit_valid, 1'b0);
        chk("rst_pkt_sent", pkt_sent, 1'b0);
        chk("rst_drop", drop, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_pl_ready", pl_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Single-flit unicast: exact latency
        for (int i = 0; i < 16; i++) pw[i] = rand64();
        model_req(1'b0, 11'd5, 56'd0, 4'd0, 52'h3, dr);
        tick();
        chk("t1_busy", busy, 1'b1);
        chk("t1_req_ready", req_ready, 1'b0);
        chk("t1_no_flit_yet", flit_valid, 1'b0);
        tick();
        chk("t1_valid", flit_valid, 1'b1);
        chk("t1_flit", flit_out, {2'b11, 1'b0, 11'd5, 52'h3});
        chk("t1_pkt_sent", pkt_sent, 1'b1);
        tick();
        chk("t1_valid_one_cycle", flit_valid, 1'b0);
        chk("t1_idle", busy, 1'b0);
        chk("t1_req_ready_back", req_ready, 1'b1);
        refill();

        // Multicast 0x111 with payload A, B (head mask depends on self-strip build)
        pw[0] = 64'hA; pw[1] = 64'hB;
        run_pkt(1'b1, 11'd0, 56'h111, 4'd2, 52'd0, 100, 50);
        refill();

        // Credit exhaustion and same-edge launch/credit
        for (int i = 0; i < 16; i++) pw[i] = rand64();
        model_req(1'b0, 11'd9, 56'd0, 4'd6, 52'h5A5, dr);
        launches = 0;
        pl_valid = 1'b1;
        repeat (20) tick();
        chk("stall_launches", launches, 4);
        chk("stall_pl_ready", pl_ready, 1'b0);
        chk("stall_flit_valid", flit_valid, 1'b0);
        credit_in = 1'b1; tick(); credit_in = 1'b0;
        repeat (5) tick();
        chk("one_credit_one_flit", launches, 5);
        credit_in = 1'b1; tick(); tick(); credit_in = 1'b0;
        repeat (5) tick();
        chk("same_edge_launches", launches, 7);
        chk("credit_pkt_left", expq.size(), 0);
        pl_valid = 1'b0;
        refill();

        // Empty multicast with no payload drops at once
        model_req(1'b1, 11'd0, 56'd0, 4'd0, 52'd0, dr);
        tick();
        chk("drop0_pulse", drop, 1'b1);
        chk("drop0_busy", busy, 1'b0);
        chk("drop0_req_ready", req_ready, 1'b1);
        tick();
        chk("drop0_one_cycle", drop, 1'b0);

        for (int i = 0; i < 16; i++) pw[i] = rand64();
        run_pkt(1'b1, 11'd0, 56'd0, 4'd2, 52'd0, 100, 0);
        run_pkt(1'b1, 11'd0, 56'h1, 4'd2, 52'd0, 100, 50);
        refill();

        // Reset in the middle of a body
        for (int i = 0; i < 16; i++) pw[i] = rand64();
        model_req(1'b0, 11'd3, 56'd0, 4'd3, 52'h77, dr);
        launches = 0;
        pl_valid = 1'b1;
        c = 0;
        while (launches < 2 && c < 20) begin
            tick();
            c++;
        end
        chk("pre_rst_launches", launches, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_flit_valid", flit_valid, 1'b0);
        chk("mid_rst_flit_out", flit_out, 66'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_req_ready", req_ready, 1'b1);
        chk("mid_rst_pl_ready", pl_ready, 1'b0);
        expq.delete();
        model_cnt = CREDITS;
        pl_valid = 1'b0;
        req_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        // Four flits with no credit returns only complete if the counter came back full
        for (int i = 0; i < 16; i++) pw[i] = rand64();
        run_pkt(1'b0, 11'd60, 56'd0, 4'd3, 52'h123, 100, 0);
        refill();

        // Randomized packets
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 16; i++) pw[i] = rand64();
            r = rand64();
            case ($urandom_range(3))
                0:       m = 56'd0;
                1:       m = 56'h1;
                default: m = r[55:0];
            endcase
            r = rand64();
            run_pkt(1'($urandom_range(1)), 11'($urandom_range(2047)), m,
                    4'($urandom_range(15)), r[51:0], int'($urandom_range(100, 30)),
                    int'($urandom_range(100, 20)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
